// File: rtl/csr_rmw_sequencer.sv
// CSR read-modify-write sequencer: one CSRRW/RS/RC per transaction, sequenced as
// read, optional write-back, then a held response toward commit.
module csr_rmw_sequencer #(
   parameter int NUM_THREADS   = 4,
   parameter int NUM_WARPS     = 4,
   parameter int UUID_BITS     = 44,
   parameter int CSR_ADDR_BITS = 12,
   localparam int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic [UUID_BITS-1:0]        req_uuid,
   input  logic [NW_BITS-1:0]          req_wid,
   input  logic [NUM_THREADS-1:0]      req_tmask,
   input  logic [31:0]                 req_pc,
   input  logic [4:0]                  req_rd,
   input  logic                        req_wb,
   input  logic [1:0]                  req_op,
   input  logic [CSR_ADDR_BITS-1:0]    req_addr,
   input  logic                        req_use_imm,
   input  logic [4:0]                  req_imm,
   input  logic [31:0]                 req_rs1_data,
   input  logic                        req_rs1_is_x0,
   input  logic [NUM_WARPS-1:0]        fpu_pending,
   output logic                        csr_read_enable,
   output logic [UUID_BITS-1:0]        csr_read_uuid,
   output logic [CSR_ADDR_BITS-1:0]    csr_read_addr,
   output logic [NW_BITS-1:0]          csr_read_wid,
   input  logic [31:0]                 csr_read_data,
   output logic                        csr_write_enable,
   output logic [UUID_BITS-1:0]        csr_write_uuid,
   output logic [CSR_ADDR_BITS-1:0]    csr_write_addr,
   output logic [NW_BITS-1:0]          csr_write_wid,
   output logic [31:0]                 csr_write_data,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [UUID_BITS-1:0]        rsp_uuid,
   output logic [NW_BITS-1:0]          rsp_wid,
   output logic [NUM_THREADS-1:0]      rsp_tmask,
   output logic [31:0]                 rsp_pc,
   output logic [4:0]                  rsp_rd,
   output logic                        rsp_wb,
   output logic [NUM_THREADS*32-1:0]   rsp_data,
   output logic                        rsp_illegal,
   output logic                        busy
);

   // state | meaning
   // IDLE  | waiting for a request, req_ready high
   // READ  | single-cycle CSR read, stalled while the FP CSR hazard holds
   // WRITE | single-cycle write-back of the new value
   // RESP  | response held until rsp_ready
   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

   localparam logic [1:0] OP_RW = 2'b01;
   localparam logic [1:0] OP_RS = 2'b10;
   localparam logic [1:0] OP_RC = 2'b11;

   state_t                     state_q, state_d;
   logic [UUID_BITS-1:0]       uuid_q, uuid_d;
   logic [NW_BITS-1:0]         wid_q, wid_d;
   logic [NUM_THREADS-1:0]     tmask_q, tmask_d;
   logic [31:0]                pc_q, pc_d;
   logic [4:0]                 rd_q, rd_d;
   logic                       wb_q, wb_d;
   logic [1:0]                 op_q, op_d;
   logic [CSR_ADDR_BITS-1:0]   addr_q, addr_d;
   logic                       use_imm_q, use_imm_d;
   logic [4:0]                 imm_q, imm_d;
   logic [31:0]                rs1_q, rs1_d;
   logic                       rs1_x0_q, rs1_x0_d;
   logic [31:0]                old_q, old_d;
   logic [31:0]                new_q, new_d;
   logic                       illegal_q, illegal_d;

   logic [31:0] src;
   logic [31:0] new_val;
   logic        need_wr;
   logic        read_only;
   logic        fp_csr;
   logic        hazard;

   always_comb begin
      src = use_imm_q ? {27'b0, imm_q} : rs1_q;
      case (op_q)
         OP_RW:   new_val = src;
         OP_RS:   new_val = csr_read_data | src;
         OP_RC:   new_val = csr_read_data & ~src;
         default: new_val = csr_read_data;
      endcase
      // set/clear with a zero source is architecturally a pure read
      need_wr   = (op_q == OP_RW) ||
                  (((op_q == OP_RS) || (op_q == OP_RC)) &&
                   (use_imm_q ? (imm_q != 5'd0) : !rs1_x0_q));
      read_only = (addr_q[CSR_ADDR_BITS-1 -: 2] == 2'b11);
      fp_csr    = (addr_q == CSR_ADDR_BITS'(1)) || (addr_q == CSR_ADDR_BITS'(2)) ||
                  (addr_q == CSR_ADDR_BITS'(3));
      hazard    = fp_csr && fpu_pending[wid_q];
   end

   always_comb begin
      state_d          = state_q;
      uuid_d           = uuid_q;
      wid_d            = wid_q;
      tmask_d          = tmask_q;
      pc_d             = pc_q;
      rd_d             = rd_q;
      wb_d             = wb_q;
      op_d             = op_q;
      addr_d           = addr_q;
      use_imm_d        = use_imm_q;
      imm_d            = imm_q;
      rs1_d            = rs1_q;
      rs1_x0_d         = rs1_x0_q;
      old_d            = old_q;
      new_d            = new_q;
      illegal_d        = illegal_q;
      req_ready        = 1'b0;
      csr_read_enable  = 1'b0;
      csr_write_enable = 1'b0;
      rsp_valid        = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               uuid_d    = req_uuid;
               wid_d     = req_wid;
               tmask_d   = req_tmask;
               pc_d      = req_pc;
               rd_d      = req_rd;
               wb_d      = req_wb;
               op_d      = req_op;
               addr_d    = req_addr;
               use_imm_d = req_use_imm;
               imm_d     = req_imm;
               rs1_d     = req_rs1_data;
               rs1_x0_d  = req_rs1_is_x0;
               illegal_d = 1'b0;
               state_d   = S_READ;
            end
         end
         S_READ: begin
            if (!hazard) begin
               csr_read_enable = 1'b1;
               old_d           = csr_read_data;
               new_d           = new_val;
               if (need_wr && !read_only) begin
                  state_d = S_WRITE;
               end else begin
                  illegal_d = need_wr;
                  state_d   = S_RESP;
               end
            end
         end
         S_WRITE: begin
            csr_write_enable = 1'b1;
            state_d          = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // the current cycle is being discarded, so nothing may be strobed or offered
      if (reset) begin
         req_ready        = 1'b0;
         csr_read_enable  = 1'b0;
         csr_write_enable = 1'b0;
         rsp_valid        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         uuid_q    <= '0;
         wid_q     <= '0;
         tmask_q   <= '0;
         pc_q      <= '0;
         rd_q      <= '0;
         wb_q      <= 1'b0;
         op_q      <= '0;
         addr_q    <= '0;
         use_imm_q <= 1'b0;
         imm_q     <= '0;
         rs1_q     <= '0;
         rs1_x0_q  <= 1'b0;
         old_q     <= '0;
         new_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         uuid_q    <= uuid_d;
         wid_q     <= wid_d;
         tmask_q   <= tmask_d;
         pc_q      <= pc_d;
         rd_q      <= rd_d;
         wb_q      <= wb_d;
         op_q      <= op_d;
         addr_q    <= addr_d;
         use_imm_q <= use_imm_d;
         imm_q     <= imm_d;
         rs1_q     <= rs1_d;
         rs1_x0_q  <= rs1_x0_d;
         old_q     <= old_d;
         new_q     <= new_d;
         illegal_q <= illegal_d;
      end
   end

   assign csr_read_uuid  = uuid_q;
   assign csr_read_addr  = addr_q;
   assign csr_read_wid   = wid_q;
   assign csr_write_uuid = uuid_q;
   assign csr_write_addr = addr_q;
   assign csr_write_wid  = wid_q;
   assign csr_write_data = new_q;
   assign rsp_uuid       = uuid_q;
   assign rsp_wid        = wid_q;
   assign rsp_tmask      = tmask_q;
   assign rsp_pc         = pc_q;
   assign rsp_rd         = rd_q;
   assign rsp_wb         = wb_q;
   assign rsp_data       = {NUM_THREADS{old_q}};
   assign rsp_illegal    = illegal_q;
   assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_csr_rmw_sequencer.sv
// Bench for csr_rmw_sequencer: directed and random CSR transactions checked
// cycle by cycle against a behavioural CSR model held in the bench.
module tb_csr_rmw_sequencer;
   localparam int NT = 4;
   localparam int NWP = 4;
   localparam int UB = 44;
   localparam int AB = 12;
   localparam int NWB = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            req_valid, req_ready;
   logic [UB-1:0]   req_uuid;
   logic [NWB-1:0]  req_wid;
   logic [NT-1:0]   req_tmask;
   logic [31:0]     req_pc;
   logic [4:0]      req_rd;
   logic            req_wb;
   logic [1:0]      req_op;
   logic [AB-1:0]   req_addr;
   logic            req_use_imm;
   logic [4:0]      req_imm;
   logic [31:0]     req_rs1_data;
   logic            req_rs1_is_x0;
   logic [NWP-1:0]  fpu_pending;
   logic            csr_read_enable;
   logic [UB-1:0]   csr_read_uuid;
   logic [AB-1:0]   csr_read_addr;
   logic [NWB-1:0]  csr_read_wid;
   logic [31:0]     csr_read_data;
   logic            csr_write_enable;
   logic [UB-1:0]   csr_write_uuid;
   logic [AB-1:0]   csr_write_addr;
   logic [NWB-1:0]  csr_write_wid;
   logic [31:0]     csr_write_data;
   logic            rsp_valid, rsp_ready;
   logic [UB-1:0]   rsp_uuid;
   logic [NWB-1:0]  rsp_wid;
   logic [NT-1:0]   rsp_tmask;
   logic [31:0]     rsp_pc;
   logic [4:0]      rsp_rd;
   logic            rsp_wb;
   logic [NT*32-1:0] rsp_data;
   logic            rsp_illegal;
   logic            busy;

   logic [31:0] mem [0:4095];
   int n_cmp = 0;
   int n_err = 0;

   assign csr_read_data = mem[csr_read_addr];

   always #5 clk = ~clk;

   csr_rmw_sequencer #(.NUM_THREADS(NT), .NUM_WARPS(NWP), .UUID_BITS(UB), .CSR_ADDR_BITS(AB)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid), .req_wid(req_wid),
      .req_tmask(req_tmask), .req_pc(req_pc), .req_rd(req_rd), .req_wb(req_wb), .req_op(req_op),
      .req_addr(req_addr), .req_use_imm(req_use_imm), .req_imm(req_imm),
      .req_rs1_data(req_rs1_data), .req_rs1_is_x0(req_rs1_is_x0), .fpu_pending(fpu_pending),
      .csr_read_enable(csr_read_enable), .csr_read_uuid(csr_read_uuid),
      .csr_read_addr(csr_read_addr), .csr_read_wid(csr_read_wid), .csr_read_data(csr_read_data),
      .csr_write_enable(csr_write_enable), .csr_write_uuid(csr_write_uuid),
      .csr_write_addr(csr_write_addr), .csr_write_wid(csr_write_wid),
      .csr_write_data(csr_write_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_uuid(rsp_uuid), .rsp_wid(rsp_wid),
      .rsp_tmask(rsp_tmask), .rsp_pc(rsp_pc), .rsp_rd(rsp_rd), .rsp_wb(rsp_wb),
      .rsp_data(rsp_data), .rsp_illegal(rsp_illegal), .busy(busy)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives one request starting now (just after a falling edge) and follows it
   // to the cycle after the response handshake.
   task automatic txn(input logic [1:0] op, input logic [11:0] addr, input logic ui,
                      input logic [4:0] imm, input logic [31:0] rs1, input logic x0,
                      input logic [1:0] wid, input int pend_cyc, input logic [1:0] pend_wid,
                      input int rsp_dly);
      logic [31:0] old_v, src, nv;
      logic        need, ro, wr, fp, stall;
      logic [63:0] r64;
      logic [UB-1:0] uuid;
      logic [NT-1:0] tmask;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wb;
      r64   = {$urandom(), $urandom()};
      uuid  = r64[UB-1:0];
      tmask = 4'($urandom_range(1, 15));
      pc    = $urandom();
      rd    = 5'($urandom_range(0, 31));
      wb    = 1'($urandom_range(0, 1));

      old_v = mem[addr];
      src   = ui ? 32'(imm) : rs1;
      nv    = (op == 2'd1) ? src : (op == 2'd2) ? (old_v | src) :
              (op == 2'd3) ? (old_v & ~src) : old_v;
      need  = (op == 2'd1) || (op >= 2'd2 && (ui ? imm != 0 : !x0));
      ro    = (addr >= 12'hC00);
      wr    = need && !ro;
      fp    = (addr >= 12'h001 && addr <= 12'h003);
      stall = fp && (pend_wid == wid) && (pend_cyc > 0);

      req_valid = 1'b1; req_uuid = uuid; req_wid = wid; req_tmask = tmask; req_pc = pc;
      req_rd = rd; req_wb = wb; req_op = op; req_addr = addr; req_use_imm = ui;
      req_imm = imm; req_rs1_data = rs1; req_rs1_is_x0 = x0;
      fpu_pending = '0;
      if (pend_cyc > 0) fpu_pending[pend_wid] = 1'b1;
      #1 chk("req_ready_idle", 128'(req_ready), 128'(1'b1));
      @(negedge clk);
      req_valid = 1'b0;
      #1 chk("illegal_cleared", 128'(rsp_illegal), 128'(1'b0));
      if (stall) begin
         for (int i = 0; i < pend_cyc; i++) begin
            chk("stall_rd_en", 128'(csr_read_enable), 128'(1'b0));
            chk("stall_wr_en", 128'(csr_write_enable), 128'(1'b0));
            chk("stall_busy", 128'(busy), 128'(1'b1));
            @(negedge clk);
            #1;
         end
         fpu_pending = '0;
         #1;
      end
      chk("read_en", 128'(csr_read_enable), 128'(1'b1));
      chk("read_addr", 128'(csr_read_addr), 128'(addr));
      chk("read_wid", 128'(csr_read_wid), 128'(wid));
      chk("read_uuid", 128'(csr_read_uuid), 128'(uuid));
      chk("read_no_wr", 128'(csr_write_enable), 128'(1'b0));
      chk("read_no_rsp", 128'(rsp_valid), 128'(1'b0));
      @(negedge clk);
      fpu_pending = '0;
      if (wr) begin
         #1;
         chk("write_en", 128'(csr_write_enable), 128'(1'b1));
         chk("write_data", 128'(csr_write_data), 128'(nv));
         chk("write_addr", 128'(csr_write_addr), 128'(addr));
         chk("write_wid", 128'(csr_write_wid), 128'(wid));
         chk("write_uuid", 128'(csr_write_uuid), 128'(uuid));
         chk("write_no_rd", 128'(csr_read_enable), 128'(1'b0));
         chk("write_no_rsp", 128'(rsp_valid), 128'(1'b0));
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      for (int d = 0; d <= rsp_dly; d++) begin
         #1;
         chk("rsp_valid", 128'(rsp_valid), 128'(1'b1));
         chk("rsp_data", 128'(rsp_data), {old_v, old_v, old_v, old_v});
         chk("rsp_illegal", 128'(rsp_illegal), 128'(need && ro));
         chk("rsp_uuid", 128'(rsp_uuid), 128'(uuid));
         chk("rsp_wid", 128'(rsp_wid), 128'(wid));
         chk("rsp_tmask", 128'(rsp_tmask), 128'(tmask));
         chk("rsp_pc", 128'(rsp_pc), 128'(pc));
         chk("rsp_rd", 128'(rsp_rd), 128'(rd));
         chk("rsp_wb", 128'(rsp_wb), 128'(wb));
         chk("rsp_req_ready", 128'(req_ready), 128'(1'b0));
         chk("rsp_no_strobe", 128'({csr_read_enable, csr_write_enable}), 128'(2'b00));
         if (d == rsp_dly) rsp_ready = 1'b1;
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      if (wr) mem[addr] = nv;
      #1;
      chk("post_rsp_valid", 128'(rsp_valid), 128'(1'b0));
      chk("post_busy", 128'(busy), 128'(1'b0));
   endtask

   initial begin
      logic [11:0] addr_pool [0:7];
      for (int a = 0; a < 4096; a++) mem[a] = $urandom();
      mem[12'h340] = 32'h12;
      mem[12'h341] = 32'h0F;
      addr_pool[0] = 12'h340; addr_pool[1] = 12'h001; addr_pool[2] = 12'h002;
      addr_pool[3] = 12'h003; addr_pool[4] = 12'hF11; addr_pool[5] = 12'hC00;
      addr_pool[6] = 12'h300; addr_pool[7] = 12'h7C0;

      reset = 1'b1; req_valid = 1'b0; req_uuid = '0; req_wid = '0; req_tmask = '0;
      req_pc = '0; req_rd = '0; req_wb = 1'b0; req_op = '0; req_addr = '0;
      req_use_imm = 1'b0; req_imm = '0; req_rs1_data = '0; req_rs1_is_x0 = 1'b0;
      fpu_pending = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req_ready", 128'(req_ready), 128'(1'b0));
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_rsp_valid", 128'(rsp_valid), 128'(1'b0));
      chk("rst_illegal", 128'(rsp_illegal), 128'(1'b0));
      chk("rst_strobes", 128'({csr_read_enable, csr_write_enable}), 128'(2'b00));
      reset = 1'b0;
      @(negedge clk);
      #1;

      // RW with register source, then RS imm=0 (no write), RC clearing bits
      txn(2'd1, 12'h340, 1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 2'd0, 0, 2'd0, 0);
      txn(2'd2, 12'h341, 1'b1, 5'd0, 32'h0, 1'b0, 2'd1, 0, 2'd0, 0);
      txn(2'd3, 12'h341, 1'b0, 5'd0, 32'h3, 1'b0, 2'd2, 0, 2'd0, 0);
      // FRM with own-warp FPU ops pending for 5 cycles, then another warp pending
      txn(2'd0, 12'h002, 1'b0, 5'd0, 32'h0, 1'b1, 2'd1, 5, 2'd1, 0);
      txn(2'd0, 12'h002, 1'b0, 5'd0, 32'h0, 1'b1, 2'd1, 5, 2'd2, 0);
      // write to a read-only CSR, followed by a normal op to see illegal cleared
      txn(2'd1, 12'hF11, 1'b0, 5'd0, 32'h55AA55AA, 1'b0, 2'd3, 0, 2'd0, 0);
      txn(2'd2, 12'h340, 1'b1, 5'd5, 32'h0, 1'b0, 2'd0, 0, 2'd0, 3);

      // reset while in a write-bound read
      req_valid = 1'b1; req_op = 2'd1; req_addr = 12'h340; req_use_imm = 1'b0;
      req_rs1_data = 32'hCAFEF00D; req_rs1_is_x0 = 1'b0; req_wid = 2'd0;
      @(negedge clk);
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rstmid_req_ready", 128'(req_ready), 128'(1'b0));
      chk("rstmid_strobes", 128'({csr_read_enable, csr_write_enable}), 128'(2'b00));
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rstmid_busy", 128'(busy), 128'(1'b0));
      chk("rstmid_wr_en", 128'(csr_write_enable), 128'(1'b0));
      chk("rstmid_rsp_valid", 128'(rsp_valid), 128'(1'b0));
      @(negedge clk);
      #1;
      chk("rstmid_wr_en2", 128'(csr_write_enable), 128'(1'b0));
      chk("rstmid_rsp_valid2", 128'(rsp_valid), 128'(1'b0));
      chk("rstmid_ready", 128'(req_ready), 128'(1'b1));

      for (int t = 0; t < 60; t++) begin
         logic [11:0] a;
         logic        x0, ui;
         logic [4:0]  im;
         logic [31:0] r;
         a  = ($urandom_range(0, 9) < 8) ? addr_pool[$urandom_range(0, 7)] : 12'($urandom());
         ui = 1'($urandom_range(0, 1));
         im = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         x0 = ($urandom_range(0, 3) == 0);
         r  = x0 ? 32'h0 : $urandom();
         txn(2'($urandom_range(0, 3)), a, ui, im, r, x0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 3), 2'($urandom_range(0, 3)), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
